// File: rtl/ldpc_layer_scheduler_if.sv
// Handshake and strobe bundle between the decoder top, the layer scheduler,
// the LLR memory and the check-node datapath.
interface ldpc_layer_scheduler_if #(
    parameter int ROW_AW = 2,
    parameter int ITER_W = 4
);
    logic              start;
    logic              abort;
    logic [ITER_W-1:0] max_iter;
    logic              row_parity;
    logic              rd_en;
    logic [ROW_AW-1:0] rd_addr;
    logic              cnu_in_valid;
    logic              wb_en;
    logic [ROW_AW-1:0] wb_addr;
    logic              busy;
    logic              done;
    logic              converged;
    logic [ITER_W-1:0] iter_count;

    modport master (
        output start, abort, max_iter, row_parity,
        input  rd_en, rd_addr, cnu_in_valid, wb_en, wb_addr,
               busy, done, converged, iter_count
    );

    modport slave (
        input  start, abort, max_iter, row_parity,
        output rd_en, rd_addr, cnu_in_valid, wb_en, wb_addr,
               busy, done, converged, iter_count
    );
endinterface

// File: rtl/ldpc_layer_scheduler.sv
// Layered LDPC row sequencer: reads each row once per iteration, tracks rows through
// the fixed-latency check-node pipe, and iterates until parity passes or budget ends.
module ldpc_layer_scheduler #(
    parameter int W       = 6,
    parameter int Wc      = 18,
    parameter int ROWS    = 4,
    parameter int ROW_AW  = 2,
    parameter int CNU_LAT = 2,
    parameter int ITER_W  = 4
) (
    input logic clk,
    input logic rst,
    ldpc_layer_scheduler_if.slave bus
);
    if (ROWS < 2 || ROWS > (1 << ROW_AW) || CNU_LAT < 1 || W < 2 || Wc < 1) begin : gBadParams
        $error("ldpc_layer_scheduler: illegal parameter combination");
    end

    typedef enum logic [2:0] {IDLE, READ, DRAIN, CHECK, DONE} state_t;

    localparam logic [ROW_AW-1:0] LastRow = ROW_AW'(ROWS - 1);

    state_t                         state;
    logic                           rdEn;
    logic [ROW_AW-1:0]              rdAddr;
    logic [CNU_LAT:0]               vldPipe;
    logic [CNU_LAT:0][ROW_AW-1:0]   addrPipe;
    logic                           fail;
    logic [ITER_W-1:0]              budget;
    logic [ITER_W-1:0]              iterCount;
    logic                           busyR;
    logic                           doneR;
    logic                           convR;

    logic [ITER_W-1:0] iterNext;
    logic              lastWb;

    assign iterNext = iterCount + 1'b1;
    // The last row's write-back ends the drain; its parity lands in fail on the same edge.
    assign lastWb   = vldPipe[CNU_LAT] && (addrPipe[CNU_LAT] == LastRow);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rdEn      <= 1'b0;
            rdAddr    <= '0;
            vldPipe   <= '0;
            addrPipe  <= '0;
            fail      <= 1'b0;
            budget    <= '0;
            iterCount <= '0;
            busyR     <= 1'b0;
            doneR     <= 1'b0;
            convR     <= 1'b0;
        end else if (bus.abort) begin
            // iterCount and converged deliberately keep their values
            state   <= IDLE;
            rdEn    <= 1'b0;
            vldPipe <= '0;
            busyR   <= 1'b0;
            doneR   <= 1'b0;
        end else begin
            vldPipe  <= {vldPipe[CNU_LAT-1:0], rdEn};
            addrPipe <= {addrPipe[CNU_LAT-1:0], rdAddr};
            doneR    <= 1'b0;
            if (vldPipe[CNU_LAT] && bus.row_parity) fail <= 1'b1;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        budget    <= (bus.max_iter == '0) ? ITER_W'(1) : bus.max_iter;
                        iterCount <= '0;
                        convR     <= 1'b0;
                        fail      <= 1'b0;
                        rdEn      <= 1'b1;
                        rdAddr    <= '0;
                        busyR     <= 1'b1;
                        state     <= READ;
                    end
                end
                READ: begin
                    if (rdAddr == LastRow) begin
                        rdEn  <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        rdAddr <= rdAddr + 1'b1;
                    end
                end
                DRAIN: begin
                    if (lastWb) state <= CHECK;
                end
                CHECK: begin
                    iterCount <= iterNext;
                    if (!fail) begin
                        convR <= 1'b1;
                        doneR <= 1'b1;
                        state <= DONE;
                    end else if (iterNext == budget) begin
                        convR <= 1'b0;
                        doneR <= 1'b1;
                        state <= DONE;
                    end else begin
                        fail   <= 1'b0;
                        rdEn   <= 1'b1;
                        rdAddr <= '0;
                        state  <= READ;
                    end
                end
                DONE: begin
                    busyR <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rd_en        = rdEn;
    assign bus.rd_addr      = rdAddr;
    assign bus.cnu_in_valid = vldPipe[0];
    assign bus.wb_en        = vldPipe[CNU_LAT];
    assign bus.wb_addr      = addrPipe[CNU_LAT];
    assign bus.busy         = busyR;
    assign bus.done         = doneR;
    assign bus.converged    = convR;
    assign bus.iter_count   = iterCount;
endmodule

// File: doc/ldpc_layer_scheduler.md
# ldpc_layer_scheduler

Sequencing controller for the shared check-node datapath: the sign/magnitude splitter followed by the min-finder and write-back stage. It walks every parity-check row of the code once per iteration and issues one read of each row's Wc LLRs. It tracks each row through the fixed-latency check-node pipeline, collects per-row parity from the sign bits, and repeats until all parity checks pass or the iteration budget runs out. It sits between the decoder top-level (start/done handshake) and the LLR memory plus check-node unit.

## Interface
Parameters:
- W, 6, LLR width in bits (sign + W-1 magnitude); passed through to the datapath, no logic here depends on it
- Wc, 18, row weight (LLRs per row); passed through
- ROWS, 4, parity-check rows per iteration, ≥2
- ROW_AW, 2, row address width, 2^ROW_AW ≥ ROWS
- CNU_LAT, 2, cycles from cnu_in_valid to the check-node result, ≥1
- ITER_W, 4, iteration counter width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin decode; sampled only in IDLE
- abort  in  1  synchronous abort; highest priority after rst
- max_iter  in  ITER_W  iteration budget, latched on accepted start; 0 is treated as 1
- row_parity  in  1  XOR of the row's sign bits from the datapath, valid when wb_en=1
- rd_en  out  1  LLR memory read strobe
- rd_addr  out  ROW_AW  row being read
- cnu_in_valid  out  1  memory data for the row is presented to the check-node input this cycle
- wb_en  out  1  check-node result valid; write back to wb_addr
- wb_addr  out  ROW_AW  row being written back
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- done  out  1  one-cycle pulse at end of decode
- converged  out  1  valid with done, held until the next accepted start
- iter_count  out  ITER_W  completed iterations, held until the next accepted start

## Operation
- States: IDLE, READ, DRAIN, CHECK, DONE.
- IDLE, start=1:
  - latch max_iter; clear iter_count, converged, the fail flag and the row counter
  - next state READ
  - start while busy is ignored
- READ:
  - each cycle: rd_en=1, rd_addr=row, then row increments
  - after issuing row ROWS-1, go to DRAIN
- Pipeline: a (1+CNU_LAT)-deep shift register of {valid, addr}.
  - cnu_in_valid is rd_en delayed 1 cycle.
  - wb_en/wb_addr are rd_en/rd_addr delayed 1+CNU_LAT cycles.
- Fail flag: set when wb_en=1 and row_parity=1; never cleared within an iteration.
- DRAIN: stay until the cycle after the last wb_en of the iteration, then go to CHECK.
- CHECK (1 cycle):
  - iter_count increments
  - if fail=0: converged←1, next state DONE
  - else if the incremented count equals the latched budget: converged←0, next state DONE
  - else: clear fail and row, next state READ
- DRAIN and CHECK see the fail flag after the last write-back's parity has been sampled.
- DONE: done=1 for one cycle, busy=1, then IDLE.
- abort in any state:
  - next state IDLE
  - pipeline valid bits cleared, so no further wb_en
  - no done pulse
  - iter_count and converged keep their current values
- rst: all state and outputs go to 0 (state IDLE, all strobes 0, busy 0, iter_count 0, converged 0).
- iter_count cannot wrap: the budget is ≤ 2^ITER_W−1.

## Timing
- Accepted start at cycle 0. READ occupies cycles 1..ROWS.
- Row r:
  - rd_en at cycle 1+r
  - cnu_in_valid at 2+r
  - wb_en at 2+r+CNU_LAT
- DRAIN occupies cycles ROWS+1..ROWS+CNU_LAT+1.
- CHECK is at cycle ROWS+CNU_LAT+2.
- One iteration takes ROWS+CNU_LAT+2 cycles.
- done pulses at k·(ROWS+CNU_LAT+2)+1 for completion after k iterations.
- At most one rd_en and one wb_en per cycle. rd_en and wb_en may overlap only in the same iteration, and never to the same row in the same cycle.

## Test plan
All scenarios use ROWS=4, CNU_LAT=2.
- Reset: hold rst 2 cycles with start=1 → every output 0; no rd_en until start is sampled after rst falls.
- Converge in iteration 1: start at cycle 0, max_iter=3, row_parity=0 always →
  - rd_en cycles 1–4, addr 0,1,2,3
  - cnu_in_valid cycles 2–5
  - wb_en cycles 4–7, addr 0–3
  - done at cycle 9 with converged=1, iter_count=1
- Budget exhausted: max_iter=2, row_parity=1 on row 2 every iteration →
  - second READ starts at cycle 9
  - done at cycle 17 with converged=0, iter_count=2
- max_iter=0: parity always failing → exactly 1 iteration; done at cycle 9, iter_count=1, converged=0.
- Abort at cycle 5 during row 3 write-back latency → no wb_en after cycle 5; busy 0 at cycle 6; no done pulse; a new start at cycle 7 is accepted.
- start pulsed at cycles 3 and 9 during a 2-iteration decode → both ignored; exactly one done.
